router_out_port_rr: RTL

Parametrised output port for the next-generation RaveNoC router: merges `NUM_IN` input channels onto one output link using round-robin wormhole arbitration and an elastic output FIFO. Generalises the fixed four-requester output stage with configurable channel count, flit width and buffer depth. Once a head flit wins arbitration, the winning input holds the output until the tail flit arrives. The block sits between the router's input-module crossbar and the external link toward the neighbouring router or local NI.

---
 rtl/router_out_port_rr.sv | 139 +++++++++++++
 1 files changed

// File: rtl/router_out_port_rr.sv
// Round-robin wormhole output port: NUM_IN channels merged onto one link through an elastic FIFO.
// Optional RAVENOC_OUT_BYPASS_EN macro: zero-latency pass-through when the FIFO is empty and downstream is ready.
//
// state     | meaning
// ST_IDLE   | no packet owns the port; heads (type 00/11) arbitrate from rr_ptr
// ST_LOCKED | owner_q holds the port until its tail (type 10) is accepted
module router_out_port_rr #(
   parameter int NUM_IN     = 4,
   parameter int FLIT_WIDTH = 34,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           arst,
   input  logic [NUM_IN-1:0]              in_valid_i,
   input  logic [NUM_IN*FLIT_WIDTH-1:0]   in_data_i,
   output logic [NUM_IN-1:0]              in_ready_o,
   output logic                           out_valid_o,
   output logic [FLIT_WIDTH-1:0]          out_data_o,
   input  logic                           out_ready_i,
   output logic                           lock_o,
   output logic [NUM_IN-1:0]              grant_o,
   output logic [$clog2(FIFO_DEPTH):0]    fill_o
);
   localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, rd_ptr_q, fill;
   logic                  full, empty;
   logic [IW-1:0]         win_idx, sel_idx;
   logic                  win_found, sel_valid, accept, bypass, fifo_wr, fifo_rd;
   logic [NUM_IN-1:0]     grant_v;
   logic [FLIT_WIDTH-1:0] sel_flit;
   logic [1:0]            sel_type;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
      return (int'(x) == NUM_IN - 1) ? '0 : x + 1'b1;
   endfunction

   assign fill  = wr_ptr_q - rd_ptr_q;
   assign full  = (fill == (AW+1)'(FIFO_DEPTH));
   assign empty = (fill == '0);

   // Head-type flits (00 or 11) have equal type bits.
   always_comb begin
      int idx;
      logic [1:0] typ;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         typ = in_data_i[idx*FLIT_WIDTH + FLIT_WIDTH-2 +: 2];
         if (!win_found && in_valid_i[idx] && (typ[1] == typ[0])) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   always_comb begin
      sel_idx   = (state_q == ST_LOCKED) ? owner_q : win_idx;
      sel_valid = (state_q == ST_LOCKED) ? in_valid_i[owner_q] : win_found;
      sel_flit  = in_data_i[int'(sel_idx)*FLIT_WIDTH +: FLIT_WIDTH];
      sel_type  = sel_flit[FLIT_WIDTH-1 -: 2];
      grant_v   = '0;
      if (state_q == ST_LOCKED || win_found) grant_v[sel_idx] = 1'b1;
   end

   // Outputs forced quiet while reset is held, even if upstream still shows valid.
   assign grant_o    = arst ? grant_v : '0;
   assign in_ready_o = (arst && !full) ? grant_v : '0;
   assign accept     = sel_valid && arst && !full;

`ifdef RAVENOC_OUT_BYPASS_EN
   assign bypass = accept & empty & out_ready_i;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_wr     = accept & ~bypass;
   assign fifo_rd     = ~empty & out_ready_i;
   assign out_valid_o = ~empty | bypass;
   assign out_data_o  = !empty ? mem_q[rd_ptr_q[AW-1:0]] : (bypass ? sel_flit : '0);
   assign fill_o      = fill;
   assign lock_o      = (state_q == ST_LOCKED);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (sel_type == 2'b00) begin
                  state_d = ST_LOCKED;
                  owner_d = win_idx;
               end else if (sel_type == 2'b11) begin
                  rr_ptr_d = wrap_inc(win_idx);
               end
            end
            ST_LOCKED: begin
               if (sel_type == 2'b10) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = wrap_inc(owner_q);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: out_data_o is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= sel_flit;
   end

endmodule
